// File: rtl/sa_rr_nport.sv
// N-port switch allocator: per-output round-robin arbitration with registered data/valid.
// Define SA_AGE_PRIO_EN to let the oldest timestamp win, with round-robin breaking ties.
module sa_rr_nport #(
    parameter int NPORT    = 5,
    parameter int DATASIZE = 40,
    parameter int TS_LSB   = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NPORT*NPORT-1:0]    label,
    input  logic [NPORT*DATASIZE-1:0] data_in,
    input  logic [NPORT-1:0]          out_full,
    output logic [NPORT-1:0]          in_ready,
    output logic [NPORT-1:0]          out_valid,
    output logic [NPORT*DATASIZE-1:0] data_out
);
    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    // A misplaced timestamp field leaves an empty marker block in the elaborated hierarchy.
    if (TS_LSB < 0 || TS_LSB + 8 > DATASIZE) begin : g_ts_field_outside_flit
    end

    logic [NPORT-1:0]    req [NPORT];
    logic [PW-1:0]       ptr [NPORT];
    logic [NPORT-1:0]    gnt_valid;
    logic [PW-1:0]       gnt_idx [NPORT];
    logic [DATASIZE-1:0] gnt_data [NPORT];

`ifdef SA_AGE_PRIO_EN
    function automatic logic older(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        d = b - a;
        return (d != 8'd0) && !d[7];
    endfunction
`endif

    // Only the lowest set label bit counts, so a malformed multi-hot label still requests one output.
    always_comb begin : p_req
        logic [NPORT-1:0] lbl;
        logic [NPORT-1:0] low;
        lbl = '0;
        low = '0;
        for (int o = 0; o < NPORT; o++) req[o] = '0;
        for (int i = 0; i < NPORT; i++) begin
            lbl = label[i*NPORT +: NPORT];
            low = lbl & (~lbl + NPORT'(1));
            for (int o = 0; o < NPORT; o++) req[o][i] = low[o];
        end
    end

    always_comb begin : p_arb
        int            idx;
        logic [PW-1:0] sel;
        logic          found;
`ifdef SA_AGE_PRIO_EN
        logic [7:0]    best_ts;
        logic [7:0]    cand_ts;
        best_ts = '0;
        cand_ts = '0;
`endif
        idx   = 0;
        sel   = '0;
        found = 1'b0;
        for (int o = 0; o < NPORT; o++) begin
            gnt_idx[o] = '0;
            found      = 1'b0;
            if (rst_n && !out_full[o]) begin
                for (int k = 0; k < NPORT; k++) begin
                    idx = int'(ptr[o]) + k;
                    if (idx >= NPORT) idx = idx - NPORT;
                    sel = PW'(idx);
                    if (req[o][sel]) begin
`ifdef SA_AGE_PRIO_EN
                        // Scanning in round-robin order and replacing only on strictly older keeps ties fair.
                        cand_ts = data_in[int'(sel)*DATASIZE + TS_LSB +: 8];
                        if (!found || older(cand_ts, best_ts)) begin
                            found      = 1'b1;
                            best_ts    = cand_ts;
                            gnt_idx[o] = sel;
                        end
`else
                        if (!found) begin
                            found      = 1'b1;
                            gnt_idx[o] = sel;
                        end
`endif
                    end
                end
            end
            gnt_valid[o] = found;
        end
    end

    always_comb begin : p_ready
        in_ready = '0;
        for (int o = 0; o < NPORT; o++) begin
            gnt_data[o] = '0;
            for (int i = 0; i < NPORT; i++) begin
                if (gnt_idx[o] == PW'(i)) begin
                    gnt_data[o] = data_in[i*DATASIZE +: DATASIZE];
                    if (gnt_valid[o]) in_ready[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int o = 0; o < NPORT; o++) ptr[o] <= '0;
            out_valid <= '0;
            data_out  <= '0;
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                out_valid[o] <= gnt_valid[o];
                if (gnt_valid[o]) begin
                    data_out[o*DATASIZE +: DATASIZE] <= gnt_data[o];
                    ptr[o] <= (gnt_idx[o] == PW'(NPORT-1)) ? '0 : gnt_idx[o] + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sa_rr_nport.sv
// Scoreboard bench for sa_rr_nport (NPORT=5): directed vectors push expected flits,
// a monitor pops them against out_valid/data_out one cycle later.
module tb_sa_rr_nport;
    localparam int NPORT    = 5;
    localparam int DATASIZE = 40;
    localparam int TS_LSB   = 24;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NPORT*NPORT-1:0]    label;
    logic [NPORT*DATASIZE-1:0] data_in;
    logic [NPORT-1:0]          out_full;
    logic [NPORT-1:0]          in_ready;
    logic [NPORT-1:0]          out_valid;
    logic [NPORT*DATASIZE-1:0] data_out;

    typedef struct packed {
        logic [3:0]          port;
        logic [DATASIZE-1:0] data;
    } sb_t;

    sb_t  sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic mon_en = 1'b1;

    always #5 clk = ~clk;

    sa_rr_nport #(.NPORT(NPORT), .DATASIZE(DATASIZE), .TS_LSB(TS_LSB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .label    (label),
        .data_in  (data_in),
        .out_full (out_full),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .data_out (data_out)
    );

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [NPORT*NPORT-1:0] mk_lbl(input int d0, input int d1, input int d2, input int d3, input int d4);
        int d [NPORT];
        logic [NPORT*NPORT-1:0] l;
        d = '{d0, d1, d2, d3, d4};
        l = '0;
        for (int i = 0; i < NPORT; i++)
            if (d[i] >= 0) l[i*NPORT + d[i]] = 1'b1;
        return l;
    endfunction

    function automatic logic [DATASIZE-1:0] mk_flit(input int src, input logic [7:0] ts, input int payload);
        return {4'(src), 4'd0, ts, 22'(payload), 2'b01};
    endfunction

    // gnt holds one nibble per output (output o at [o*4 +: 4]); 4'hF means no grant expected.
    task automatic applyStimulus(input logic rst, input logic [NPORT*NPORT-1:0] lbl, input logic [NPORT-1:0] full,
                                 input logic [8*NPORT-1:0] ts, input logic [4*NPORT-1:0] gnt);
        logic [NPORT-1:0] exp_ready;
        logic [3:0]       src;
        sb_t              e;
        @(negedge clk);
        cyc++;
        rst_n    = rst;
        label    = lbl;
        out_full = full;
        for (int i = 0; i < NPORT; i++)
            data_in[i*DATASIZE +: DATASIZE] = mk_flit(i, ts[i*8 +: 8], cyc*16 + i);
        #1;
        exp_ready = '0;
        for (int o = 0; o < NPORT; o++) begin
            src = gnt[o*4 +: 4];
            if (src != 4'hF) begin
                exp_ready[src] = 1'b1;
                e.port = 4'(o);
                e.data = data_in[int'(src)*DATASIZE +: DATASIZE];
                sb_q.push_back(e);
            end
        end
        checkOutput($sformatf("in_ready cycle %0d", cyc), 256'(in_ready), 256'(exp_ready));
    endtask

    always @(posedge clk) begin : monitor
        logic [NPORT-1:0]    ev;
        logic [DATASIZE-1:0] ed [NPORT];
        sb_t                 e;
        if (mon_en) begin
            #2;
            ev = '0;
            for (int o = 0; o < NPORT; o++) ed[o] = '0;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                ev[e.port] = 1'b1;
                ed[e.port] = e.data;
            end
            for (int o = 0; o < NPORT; o++) begin
                checkOutput($sformatf("out_valid[%0d] after cycle %0d", o, cyc), 256'(out_valid[o]), 256'(ev[o]));
                if (ev[o])
                    checkOutput($sformatf("data_out[%0d] after cycle %0d", o, cyc),
                                256'(data_out[o*DATASIZE +: DATASIZE]), 256'(ed[o]));
            end
        end
    end

    initial begin
        logic [NPORT*NPORT-1:0] mh;
        rst_n    = 1'b0;
        label    = '0;
        data_in  = '0;
        out_full = '0;

        // Reset with every input asking for output 1: nothing may be granted.
        applyStimulus(1'b0, mk_lbl(1, 1, 1, 1, 1), 5'b0, 40'h0, 20'hFFFFF);
        applyStimulus(1'b0, mk_lbl(1, 1, 1, 1, 1), 5'b0, 40'h0, 20'hFFFFF);
        checkOutput("data_out after reset", 256'(data_out), 256'(0));
        applyStimulus(1'b1, mk_lbl(1, 1, 1, 1, 1), 5'b0, 40'h0, 20'hFFF0F);

        // Contention on output 3 from inputs 0, 2, 4.
        applyStimulus(1'b1, mk_lbl(3, -1, 3, -1, 3), 5'b0, 40'h0, 20'hF0FFF);
        applyStimulus(1'b1, mk_lbl(3, -1, 3, -1, 3), 5'b0, 40'h0, 20'hF2FFF);
        applyStimulus(1'b1, mk_lbl(3, -1, 3, -1, 3), 5'b0, 40'h0, 20'hF4FFF);
        applyStimulus(1'b1, mk_lbl(3, -1, 3, -1, 3), 5'b0, 40'h0, 20'hF0FFF);
        applyStimulus(1'b1, mk_lbl(3, -1, 3, -1, 3), 5'b0, 40'h0, 20'hF2FFF);
        applyStimulus(1'b1, mk_lbl(3, -1, 3, -1, 3), 5'b0, 40'h0, 20'hF4FFF);

        // Same contention with output 3 full in cycles 3-4; the pointer must hold.
        applyStimulus(1'b1, mk_lbl(3, -1, 3, -1, 3), 5'b00000, 40'h0, 20'hF0FFF);
        applyStimulus(1'b1, mk_lbl(3, -1, 3, -1, 3), 5'b00000, 40'h0, 20'hF2FFF);
        applyStimulus(1'b1, mk_lbl(3, -1, 3, -1, 3), 5'b01000, 40'h0, 20'hFFFFF);
        applyStimulus(1'b1, mk_lbl(3, -1, 3, -1, 3), 5'b01000, 40'h0, 20'hFFFFF);
        applyStimulus(1'b1, mk_lbl(3, -1, 3, -1, 3), 5'b00000, 40'h0, 20'hF4FFF);
        applyStimulus(1'b1, mk_lbl(3, -1, 3, -1, 3), 5'b00000, 40'h0, 20'hF0FFF);

        // Full permutation: every output fires at once.
        applyStimulus(1'b1, mk_lbl(4, 3, 1, 0, 2), 5'b0, 40'h0, 20'h01423);

        // Bring ptr[4] to 4, then loopback 4->4 wraps it to 0, then input 0 beats input 4.
        applyStimulus(1'b1, mk_lbl(-1, -1, -1, 4, -1), 5'b0, 40'h0, 20'h3FFFF);
        applyStimulus(1'b1, mk_lbl(-1, -1, -1, -1, 4), 5'b0, 40'h0, 20'h4FFFF);
        applyStimulus(1'b1, mk_lbl(4, -1, -1, -1, 4), 5'b0, 40'h0, 20'h0FFFF);

        // Multi-hot label on input 2 (outputs 2 and 3) only requests output 2.
        mh = '0;
        mh[2*NPORT +: NPORT] = 5'b01100;
        mh[1*NPORT +: NPORT] = 5'b01000;
        applyStimulus(1'b1, mh, 5'b0, 40'h0, 20'hF12FF);

        applyStimulus(1'b1, mk_lbl(-1, -1, -1, 0, -1), 5'b00001, 40'h0, 20'hFFFFF);
        applyStimulus(1'b1, mk_lbl(-1, -1, -1, 0, -1), 5'b00000, 40'h0, 20'hFFFF3);

        // ptr[0]=3, then inputs 1 (ts FE) and 3 (ts 02) compete for output 0.
        applyStimulus(1'b1, mk_lbl(-1, -1, 0, -1, -1), 5'b0, 40'h0, 20'hFFFF2);
`ifdef SA_AGE_PRIO_EN
        applyStimulus(1'b1, mk_lbl(-1, 0, -1, 0, -1), 5'b0, 40'h000200FE00, 20'hFFFF1);
`else
        applyStimulus(1'b1, mk_lbl(-1, 0, -1, 0, -1), 5'b0, 40'h000200FE00, 20'hFFFF3);
`endif
        applyStimulus(1'b1, mk_lbl(-1, -1, 0, -1, -1), 5'b0, 40'h0, 20'hFFFF2);
        applyStimulus(1'b1, mk_lbl(-1, 0, -1, 0, -1), 5'b0, 40'h0010001000, 20'hFFFF3);

        // Reset right after a grant: that flit still appears, then everything clears.
        applyStimulus(1'b1, mk_lbl(-1, 1, -1, -1, -1), 5'b0, 40'h0, 20'hFFF1F);
        applyStimulus(1'b0, mk_lbl(-1, 1, -1, -1, -1), 5'b0, 40'h0, 20'hFFFFF);
        applyStimulus(1'b0, mk_lbl(1, 1, 1, -1, -1), 5'b0, 40'h0, 20'hFFFFF);
        checkOutput("data_out after mid reset", 256'(data_out), 256'(0));
        applyStimulus(1'b1, mk_lbl(1, -1, 1, -1, -1), 5'b0, 40'h0, 20'hFFF0F);
        applyStimulus(1'b1, mk_lbl(1, -1, 1, -1, -1), 5'b0, 40'h0, 20'hFFF2F);

        applyStimulus(1'b1, mk_lbl(-1, -1, -1, -1, -1), 5'b0, 40'h0, 20'hFFFFF);
        applyStimulus(1'b1, mk_lbl(-1, -1, -1, -1, -1), 5'b0, 40'h0, 20'hFFFFF);
        @(negedge clk);
        mon_en = 1'b0;
        checkOutput("scoreboard drained", 256'(sb_q.size()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_rr_nport.md
# sa_rr_nport

Parametrised N-port switch allocator for the mesh router: it takes the head flit and one-hot route label of every input FIFO, arbitrates each output port independently with a round-robin arbiter, and drives the registered output data/valid toward the downstream FIFOs. It replaces the fixed 4-port allocator/arbiter pair with one block whose port count is set per router position (edge, corner, interior), and it adds optional oldest-first priority.

## Interface
- NPORT, 5, number of input ports and number of output ports; index 0 = Local, 1 = N, 2 = E, 3 = S, 4 = W; range 2..8.
- DATASIZE, 40, flit width; layout src[39:36], dst[35:32], timestamp[31:24], data[23:2], type[1:0].
- TS_LSB, 24, LSB of the 8-bit timestamp field; used only when age priority is compiled in.

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- label  in  NPORT*NPORT  route label of input i at [i*NPORT +: NPORT]; one-hot output request; all-zero = no request.
- data_in  in  NPORT*DATASIZE  head flit of input i at [i*DATASIZE +: DATASIZE].
- out_full  in  NPORT  downstream FIFO of output o is full; tie unused ports to 0.
- in_ready  out  NPORT  input i granted this cycle; the input FIFO pops at this edge.
- out_valid  out  NPORT  output o carries a new flit this cycle.
- data_out  out  NPORT*DATASIZE  flit on output o at [o*DATASIZE +: DATASIZE].

## Operation
- Request: input i requests output o when label[i*NPORT+o]=1. A multi-hot label is illegal; the block honours only its lowest set bit.
- Loopback is allowed: input i may request output i.
- Per output o, each cycle: the eligible set is the requesting inputs. If out_full[o]=1 or the set is empty, there is no grant.
- Round-robin: each output holds a pointer ptr[o] of width clog2(NPORT). The grant goes to the first eligible input at or after ptr[o], searching cyclically upward with wrap from NPORT-1 to 0.
- After a grant to input g, ptr[o] is loaded with g+1, or 0 when g=NPORT-1. Without a grant, ptr[o] holds.
- An input requests exactly one output, so it receives at most one grant. in_ready[i] is the OR of all grants to input i.
- Registered outputs on a grant edge:
  - data_out[o] ← data_in[g];
  - out_valid[o] ← 1.
- Without a grant: out_valid[o] ← 0 and data_out[o] holds its last value.
- No packet/wormhole locking: every flit is arbitrated independently.

## Timing
- Reset values, rst_n=0 sampled at the edge:
  - ptr[o]=0;
  - out_valid=0;
  - data_out=0.
- in_ready is forced 0 while rst_n=0.
- in_ready is combinational from label, out_full, ptr and rst_n, and is valid in the same cycle as the request.
- Latency: a flit granted in cycle t appears on data_out with out_valid=1 in cycle t+1.
- Throughput: one flit per output per cycle. All NPORT outputs may fire in the same cycle.
- out_full is sampled in the grant cycle. A full that rises in the same cycle as a request blocks that grant, and ptr is unchanged.
- Reset mid-operation: the next edge clears all state. A flit registered in the cycle before reset is still presented for that one cycle, then out_valid drops. An input whose in_ready was high before reset has already popped, so that flit is delivered. No grant is issued during reset.
- Pointer wrap: ptr at NPORT-1 followed by a grant to NPORT-1 gives ptr=0.

## Configuration
- SA_AGE_PRIO_EN defined:
  - Among eligible inputs of an output, the flit with the oldest timestamp wins.
  - Age compare is modulo 256: a is older than b when (b−a) mod 256 lies in 1..127.
  - Equal-age candidates, and pairs whose difference is 128, are resolved by the round-robin rule.
  - ptr[o] updates as in the base mode.
  - Adds one comparator tree per output; latency is unchanged.
- SA_AGE_PRIO_EN undefined: pure round-robin as above, and the timestamp field is ignored.

## Test plan
- Reset with NPORT=5: drive rst_n=0 for 2 cycles with all labels=5'b00010. Required: in_ready=0 throughout, out_valid=0, data_out=0. First grant after release goes to input 0 (ptr[1]=0).
- Contention, NPORT=5: inputs 0, 2 and 4 hold label 5'b01000 (output 3) for 6 cycles, out_full=0. Required: grant order 0,2,4,0,2,4. out_valid[3]=1 from cycle 2 onward, and data_out[3] matches the granted input's data one cycle later.
- Backpressure: out_full[3]=1 for cycles 3–4 during the contention test. Required: no grant and out_valid[3]=0 on the following cycles. ptr holds, and the sequence resumes at the next input in order.
- Parallel non-conflicting: input 0→output 4, 1→3, 2→1, 3→0, 4→2, all in one cycle. Required: all five in_ready=1 and all five out_valid=1 the next cycle with correct data mapping.
- Wrap and loopback: input 4 requests output 4 with ptr[4]=4. Required: grant to 4, then ptr[4]=0. Next, inputs 0 and 4 both request, and input 0 wins.
- SA_AGE_PRIO_EN: inputs 1 and 3 request output 0 with timestamps 8'hFE and 8'h02 (wrapped), ptr[0]=3. Required: input 1 wins (older). With equal timestamps 8'h10, input 3 wins.
